axis_demux: RTL and testbench

- 1:2 AXI4-Stream router: one slave stream in, two master streams out. Each beat goes to m0 or m1 according to select_in.
- Same clock domain as, and the counterpart to, the team's 2:1 stream mux. Used to send a single capture/DMA stream to one of two consumers.
- Outputs are fully registered, with a 2-entry skid buffer. s0_tready is driven from a register.
- Full throughput: one beat per cycle sustained.

---
 rtl/axis_demux.sv | 77 +++++++
 tb/tb_axis_demux.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/axis_demux.sv
// axis_demux: 1:2 AXI4-Stream router with registered outputs and a skid buffer; `define AXIS_DEMUX_PACKET_EN for per-packet route locking
module axis_demux #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  s0_tvalid,
  output logic                  s0_tready,
  input  logic [DATA_WIDTH-1:0] s0_tdata,
  input  logic                  s0_tlast,
  input  logic                  select_in,
  output logic                  m0_tvalid,
  input  logic                  m0_tready,
  output logic [DATA_WIDTH-1:0] m0_tdata,
  output logic                  m0_tlast,
  output logic                  m1_tvalid,
  input  logic                  m1_tready,
  output logic [DATA_WIDTH-1:0] m1_tdata,
  output logic                  m1_tlast
);
  logic                  out_valid, out_last, out_sel;
  logic                  skid_valid, skid_last, skid_sel;
  logic [DATA_WIDTH-1:0] out_data, skid_data;
  logic                  accept, pop, load_out, skid_load, skid_valid_nxt, beat_sel;
  assign accept         = s0_tvalid & s0_tready;
  assign pop            = out_valid & (out_sel ? m1_tready : m0_tready);
  assign load_out       = !out_valid | pop;
  assign skid_load      = accept & (!load_out | skid_valid);
  assign skid_valid_nxt = load_out ? (skid_valid & accept) : (skid_valid | accept);
  assign m0_tvalid      = out_valid & ~out_sel;
  assign m1_tvalid      = out_valid & out_sel;
  assign m0_tdata       = out_data;
  assign m1_tdata       = out_data;
  assign m0_tlast       = out_last;
  assign m1_tlast       = out_last;
`ifdef AXIS_DEMUX_PACKET_EN
  typedef enum logic {IDLE, IN_PKT} state_t;
  state_t state;
  logic   held_sel;
  assign beat_sel = (state == IN_PKT) ? held_sel : select_in;
  // Lock the route on the first beat of a packet and release it on tlast
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state    <= IDLE;
      held_sel <= 1'b0;
    end else if (accept) begin
      if (state == IDLE) held_sel <= select_in;
      state <= s0_tlast ? IDLE : IN_PKT;
    end
`else
  assign beat_sel = select_in;
`endif
  // Occupancy and registered ready; ready drops whenever the skid slot holds a beat
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      s0_tready  <= 1'b0;
    end else begin
      if (load_out) out_valid <= skid_valid | accept;
      skid_valid <= skid_valid_nxt;
      s0_tready  <= !skid_valid_nxt;
    end
  // Payload and route of each beat travel with it; skid drains ahead of new input to keep order
  always_ff @(posedge clk) begin
    if (load_out) begin
      out_data <= skid_valid ? skid_data : s0_tdata;
      out_last <= skid_valid ? skid_last : s0_tlast;
      out_sel  <= skid_valid ? skid_sel  : beat_sel;
    end
    if (skid_load) begin
      skid_data <= s0_tdata;
      skid_last <= s0_tlast;
      skid_sel  <= beat_sel;
    end
  end
endmodule

// File: tb/tb_axis_demux.sv
// tb_axis_demux: directed self-checking bench for axis_demux
module tb_axis_demux;
  logic        clk = 1'b0, resetn = 1'b0;
  logic        s0_tvalid = 1'b0, s0_tlast = 1'b0, select_in = 1'b0;
  logic [31:0] s0_tdata = '0;
  logic        s0_tready, m0_tvalid, m0_tlast, m1_tvalid, m1_tlast;
  logic        m0_tready = 1'b1, m1_tready = 1'b1;
  logic [31:0] m0_tdata, m1_tdata;
  logic [31:0] q0[$], q1[$];
  int          checks = 0, failures = 0;

  axis_demux #(.DATA_WIDTH(32)) dut (
    .clk(clk), .resetn(resetn),
    .s0_tvalid(s0_tvalid), .s0_tready(s0_tready), .s0_tdata(s0_tdata), .s0_tlast(s0_tlast),
    .select_in(select_in),
    .m0_tvalid(m0_tvalid), .m0_tready(m0_tready), .m0_tdata(m0_tdata), .m0_tlast(m0_tlast),
    .m1_tvalid(m1_tvalid), .m1_tready(m1_tready), .m1_tdata(m1_tdata), .m1_tlast(m1_tlast)
  );

  always #5 clk = ~clk;

  // Record every beat delivered on each port
  always @(posedge clk) begin
    if (m0_tvalid && m0_tready) q0.push_back(m0_tdata);
    if (m1_tvalid && m1_tready) q1.push_back(m1_tdata);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] d, input logic s, input logic l);
    s0_tvalid = 1'b1;
    s0_tdata  = d;
    select_in = s;
    s0_tlast  = l;
  endtask

  task automatic idle();
    s0_tvalid = 1'b0;
    s0_tlast  = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_tready", s0_tready, 0);
    chk("rst_m0v", m0_tvalid, 0);
    chk("rst_m1v", m1_tvalid, 0);
    resetn = 1'b1;
    tick();
    chk("post_rst_tready", s0_tready, 1);

    beat(32'h11, 0, 0); tick();
    chk("t1_b0_v", m0_tvalid, 1);
    chk("t1_b0_d", m0_tdata, 32'h11);
    beat(32'h22, 0, 0); tick();
    chk("t1_b1_d", m0_tdata, 32'h22);
    chk("t1_m1v", m1_tvalid, 0);
    beat(32'h33, 0, 1); tick();
    chk("t1_b2_d", m0_tdata, 32'h33);
    chk("t1_b2_last", m0_tlast, 1);
    idle(); tick();
    chk("t1_drain", m0_tvalid, 0);
    chk("t1_n", q0.size(), 3);
    chk("t1_q0", q0[0], 32'h11);
    chk("t1_q1", q0[1], 32'h22);
    chk("t1_q2", q0[2], 32'h33);
    chk("t1_nm1", q1.size(), 0);
    q0.delete(); q1.delete();

    beat(32'hA0, 0, 0); tick();
    chk("t2_a0_m0v", m0_tvalid, 1);
    beat(32'hA1, 1, 0); tick();
    chk("t2_a1_m1v", m1_tvalid, 1);
    chk("t2_a1_m0v", m0_tvalid, 0);
    chk("t2_a1_d", m1_tdata, 32'hA1);
    beat(32'hA2, 0, 0); tick();
    beat(32'hA3, 1, 1); tick();
    idle(); tick(); tick();
    chk("t2_n0", q0.size(), 2);
    chk("t2_n1", q1.size(), 2);
    chk("t2_q0_0", q0[0], 32'hA0);
    chk("t2_q0_1", q0[1], 32'hA2);
    chk("t2_q1_0", q1[0], 32'hA1);
    chk("t2_q1_1", q1[1], 32'hA3);
    q0.delete(); q1.delete();

    m0_tready = 1'b0;
    beat(32'h01, 0, 0); tick();
    chk("t3_e1_tready", s0_tready, 1);
    chk("t3_e1_d", m0_tdata, 32'h01);
    beat(32'h02, 0, 0); tick();
    chk("t3_full_tready", s0_tready, 0);
    beat(32'h03, 0, 0);
    repeat (3) tick();
    chk("t3_hold_tready", s0_tready, 0);
    chk("t3_hold_d", m0_tdata, 32'h01);
    m0_tready = 1'b1; tick();
    chk("t3_rel_d", m0_tdata, 32'h02);
    chk("t3_rel_tready", s0_tready, 1);
    tick();
    chk("t3_b3_d", m0_tdata, 32'h03);
    beat(32'h04, 0, 1); tick();
    idle(); tick(); tick();
    chk("t3_n", q0.size(), 4);
    chk("t3_q0", q0[0], 32'h01);
    chk("t3_q1", q0[1], 32'h02);
    chk("t3_q2", q0[2], 32'h03);
    chk("t3_q3", q0[3], 32'h04);
    q0.delete(); q1.delete();

    m0_tready = 1'b0;
    beat(32'h55, 0, 0); tick();
    beat(32'h66, 1, 0); tick();
    idle(); select_in = 1'b0;
    tick(); tick();
    chk("t4_hol_m1v", m1_tvalid, 0);
    chk("t4_hol_n1", q1.size(), 0);
    chk("t4_hol_tready", s0_tready, 0);
    m0_tready = 1'b1; tick();
    chk("t4_m1v", m1_tvalid, 1);
    chk("t4_m1d", m1_tdata, 32'h66);
    chk("t4_m0v", m0_tvalid, 0);
    tick();
    select_in = 1'b1; tick(); select_in = 1'b0; tick();
    chk("t4_idle_m0v", m0_tvalid, 0);
    chk("t4_idle_m1v", m1_tvalid, 0);
    chk("t4_n0", q0.size(), 1);
    chk("t4_q0", q0[0], 32'h55);
    chk("t4_n1", q1.size(), 1);
    chk("t4_q1", q1[0], 32'h66);
    q0.delete(); q1.delete();

`ifdef AXIS_DEMUX_PACKET_EN
    beat(32'hC0, 1, 0); tick();
    beat(32'hC1, 0, 0); tick();
    chk("t5_lock_m1v", m1_tvalid, 1);
    beat(32'hC2, 1, 0); tick();
    beat(32'hC3, 0, 1); tick();
    beat(32'hD0, 0, 1); tick();
    idle(); tick(); tick();
    chk("t5_n1", q1.size(), 4);
    chk("t5_q1_0", q1[0], 32'hC0);
    chk("t5_q1_1", q1[1], 32'hC1);
    chk("t5_q1_2", q1[2], 32'hC2);
    chk("t5_q1_3", q1[3], 32'hC3);
    chk("t5_n0", q0.size(), 1);
    chk("t5_q0", q0[0], 32'hD0);
    q0.delete(); q1.delete();
`endif

    m0_tready = 1'b0;
    beat(32'h77, 0, 0); tick();
    beat(32'h78, 0, 0); tick();
    chk("t6_full_m0v", m0_tvalid, 1);
    chk("t6_full_tready", s0_tready, 0);
    idle();
    #2 resetn = 1'b0;
    #1;
    chk("t6_rst_m0v", m0_tvalid, 0);
    chk("t6_rst_m1v", m1_tvalid, 0);
    chk("t6_rst_tready", s0_tready, 0);
    m0_tready = 1'b1;
    #2 resetn = 1'b1;
    tick();
    chk("t6_rel_tready", s0_tready, 1);
    tick(); tick();
    chk("t6_stale_m0v", m0_tvalid, 0);
    chk("t6_stale_n0", q0.size(), 0);
    chk("t6_stale_n1", q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
